gcm_block_feeder: RTL and testbench

Upstream stage of `gcm_aes`. It accepts a job command (key, IV, AAD and plaintext bit lengths) and a 32-bit word stream with valid/ready. It packs the stream into 128-bit zero-padded blocks and presents them to `gcm_aes` with the `new_instance`/`pt_instance` framing and size fields that core requires. Each block is handed off through a valid/ready handshake, so the core or an arbiter can apply backpressure.

---
 rtl/gcm_pkg.sv | 33 +++
 rtl/gcm_blk_packer.sv | 34 +++
 rtl/gcm_block_feeder.sv | 180 ++++++++++++++++++
 tb/tb_gcm_block_feeder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared constants, FSM states and byte-mask helper
// for the GCM block feeder.
package gcm_pkg;

  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int GCM_LEN_W     = 64;

  typedef enum logic [2:0] {
    IDLE,
    AAD_FILL,
    AAD_EMIT,
    PT_FILL,
    PT_EMIT,
    DONE
  } feed_state_t;

  // Keep the first `keep` bytes (big-endian) of a word.
  function automatic logic [WORD_W-1:0] byte_mask(
    input logic [2:0] keep
  );
    logic [WORD_W-1:0] m;
    case (keep)
      3'd1:    m = 32'hFF00_0000;
      3'd2:    m = 32'hFFFF_0000;
      3'd3:    m = 32'hFFFF_FF00;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gcm_blk_packer.sv
// gcm_blk_packer: assembles masked 32-bit words into one
// 128-bit block, first word in the top bits; cleared on emit.
module gcm_blk_packer
  import gcm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        keep,
  output logic [1:0]        slot,
  output logic [BLK_W-1:0]  blk
);

  logic [WORD_W-1:0] masked;

  assign masked = word & byte_mask(keep);

  // Drop each accepted word into the next slot, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      blk  <= '0;
    end else if (clr) begin
      slot <= '0;
      blk  <= '0;
    end else if (wr) begin
      blk[BLK_W-WORD_W*(int'(slot)+1) +: WORD_W] <= masked;
      slot <= slot + 2'd1;
    end
  end

endmodule

// File: rtl/gcm_block_feeder.sv
// gcm_block_feeder: packs a word stream into AAD/PT blocks for gcm_aes.
// Optional macro GCM_FEEDER_LEN_CHECK_EN checks i_word_last.
module gcm_block_feeder
  import gcm_pkg::*;
#(
  parameter int LEN_W = GCM_LEN_W
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [127:0]      i_cipher_key,
  input  logic [95:0]       i_iv,
  input  logic [LEN_W-1:0]  i_aad_len,
  input  logic [LEN_W-1:0]  i_pt_len,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_word_valid,
  input  logic              i_word_last,
  output logic              o_word_ready,
  output logic              o_blk_valid,
  input  logic              i_blk_ready,
  output logic              o_new_instance,
  output logic              o_pt_instance,
  output logic [BLK_W-1:0]  o_aad,
  output logic [BLK_W-1:0]  o_plain_text,
  output logic [LEN_W-1:0]  o_aad_size,
  output logic [LEN_W-1:0]  o_plain_text_size,
  output logic [127:0]      o_cipher_key,
  output logic [95:0]       o_iv,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_len_err
);

  // Stream byte 0 sits in bits 127:120, i.e. [0:7]
  // in gcm_aes's ascending block numbering.

  localparam logic [1:0] LAST_SLOT = 2'(WORDS_PER_BLK - 1);

  feed_state_t      state;
  logic [127:0]     key_q;
  logic [95:0]      iv_q;
  logic [LEN_W-1:0] aad_len_q;
  logic [LEN_W-1:0] pt_len_q;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] pt_bytes;
  logic             first_q;
  logic             valid_q;
  logic             new_q;
  logic             pti_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic             fill;
  logic             take;
  logic             hs;
  logic             calc_last;
  logic             eff_last;
  logic             mis;
  logic             fill_end;
  logic [2:0]       keep;
  logic [1:0]       slot;
  logic [BLK_W-1:0] blk;

  assign fill      = (state == AAD_FILL) || (state == PT_FILL);
  assign o_word_ready = fill && (rem != '0);
  assign take      = o_word_ready && i_word_valid;
  assign hs        = valid_q && i_blk_ready;
  assign calc_last = rem <= LEN_W'(4);
  assign keep      = calc_last ? rem[2:0] : 3'd4;
  assign pt_bytes  = pt_len_q >> 3;

`ifdef GCM_FEEDER_LEN_CHECK_EN
  assign eff_last = calc_last || i_word_last;
  assign mis      = take && (calc_last != i_word_last);
`else
  logic unused_last;
  assign unused_last = i_word_last;
  assign eff_last    = calc_last;
  assign mis         = 1'b0;
`endif

  // Empty AAD phase emits at once; otherwise emit
  // after the 4th word or the phase's final word.
  assign fill_end = fill && ((rem == '0) ||
                    (take && (eff_last || slot == LAST_SLOT)));

  gcm_blk_packer u_packer (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (hs),
    .wr    (take),
    .word  (i_word),
    .keep  (keep),
    .slot  (slot),
    .blk   (blk)
  );

  // Job sequencing: latch, fill, emit, next phase, done.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      key_q     <= '0;
      iv_q      <= '0;
      aad_len_q <= '0;
      pt_len_q  <= '0;
      rem       <= '0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      pti_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mis) err_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            key_q     <= i_cipher_key;
            iv_q      <= i_iv;
            aad_len_q <= i_aad_len;
            pt_len_q  <= i_pt_len;
            rem       <= i_aad_len >> 3;
            first_q   <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            state     <= AAD_FILL;
          end
        end
        AAD_FILL, PT_FILL: begin
          if (take) rem <= eff_last ? '0 : rem - LEN_W'(4);
          if (fill_end) begin
            valid_q <= 1'b1;
            new_q   <= first_q && (state == AAD_FILL);
            pti_q   <= first_q && (state == PT_FILL);
            state   <= (state == AAD_FILL) ? AAD_EMIT : PT_EMIT;
          end
        end
        AAD_EMIT, PT_EMIT: begin
          if (i_blk_ready) begin
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            pti_q   <= 1'b0;
            first_q <= 1'b0;
            if (rem != '0) begin
              state <= (state == AAD_EMIT) ? AAD_FILL : PT_FILL;
            end else if (state == AAD_EMIT && pt_bytes != '0) begin
              rem     <= pt_bytes;
              first_q <= 1'b1;
              state   <= PT_FILL;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign o_blk_valid       = valid_q;
  assign o_new_instance    = new_q;
  assign o_pt_instance     = pti_q;
  assign o_aad             = (state == AAD_EMIT) ? blk : '0;
  assign o_plain_text      = (state == PT_EMIT) ? blk : '0;
  assign o_aad_size        = aad_len_q;
  assign o_plain_text_size = pt_len_q;
  assign o_cipher_key      = key_q;
  assign o_iv              = iv_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_len_err         = err_q;

endmodule

// File: tb/tb_gcm_block_feeder.sv
// tb_gcm_block_feeder: random jobs checked against a byte-stream
// model of the expected GCM AAD/PT block sequence.
module tb_gcm_block_feeder;

  logic         clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [127:0] i_cipher_key;
  logic [95:0]  i_iv;
  logic [63:0]  i_aad_len;
  logic [63:0]  i_pt_len;
  logic [31:0]  i_word;
  logic         i_word_valid;
  logic         i_word_last;
  logic         o_word_ready;
  logic         o_blk_valid;
  logic         i_blk_ready;
  logic         o_new_instance;
  logic         o_pt_instance;
  logic [127:0] o_aad;
  logic [127:0] o_plain_text;
  logic [63:0]  o_aad_size;
  logic [63:0]  o_plain_text_size;
  logic [127:0] o_cipher_key;
  logic [95:0]  o_iv;
  logic         o_busy;
  logic         o_done;
  logic         o_len_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           pt;
    bit           first;
    logic [127:0] d;
  } eblk_t;

  eblk_t        exp_q[$];
  logic [31:0]  wq[$];
  logic [127:0] last_pt;
  logic [127:0] cur_key;
  logic [95:0]  cur_iv;
  logic [63:0]  cur_ab;
  logic [63:0]  cur_pb;

  always #5 clk = ~clk;

  gcm_block_feeder dut (
    .clk               (clk),
    .i_rst_n           (i_rst_n),
    .i_start           (i_start),
    .i_cipher_key      (i_cipher_key),
    .i_iv              (i_iv),
    .i_aad_len         (i_aad_len),
    .i_pt_len          (i_pt_len),
    .i_word            (i_word),
    .i_word_valid      (i_word_valid),
    .i_word_last       (i_word_last),
    .o_word_ready      (o_word_ready),
    .o_blk_valid       (o_blk_valid),
    .i_blk_ready       (i_blk_ready),
    .o_new_instance    (o_new_instance),
    .o_pt_instance     (o_pt_instance),
    .o_aad             (o_aad),
    .o_plain_text      (o_plain_text),
    .o_aad_size        (o_aad_size),
    .o_plain_text_size (o_plain_text_size),
    .o_cipher_key      (o_cipher_key),
    .o_iv              (o_iv),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_len_err         (o_len_err)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {o_blk_valid, o_word_ready, o_new_instance,
        o_pt_instance, o_busy, o_done, o_len_err}, 0);
    chk({tag, "_data"}, o_aad | o_plain_text, 0);
    chk({tag, "_key"}, o_cipher_key, 0);
    chk({tag, "_iv"}, o_iv, 0);
    chk({tag, "_size"}, {o_aad_size, o_plain_text_size}, 0);
  endtask

  // Byte stream -> 16-byte zero-padded blocks.
  task automatic build(input int nbytes, input int off,
                       input bit pt, input bit one);
    int    nblk;
    eblk_t e;
    logic [31:0] w;
    nblk = (nbytes + 15) / 16;
    if (one && nblk == 0) nblk = 1;
    for (int b = 0; b < nblk; b++) begin
      e.pt    = pt;
      e.first = (b == 0);
      e.d     = '0;
      for (int j = 0; j < 16; j++) begin
        int k;
        k = b * 16 + j;
        if (k < nbytes) begin
          w = wq[off + k / 4];
          e.d[127-8*j -: 8] = w[31-8*(k%4) -: 8];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic run_job(input int ab, input int pb, input int vmode,
                         input int rmode, input int cut, input bit fixed,
                         input bit rst_mid, input int exp_cyc);
    int    anb, pnb, aw, pw, asend, total;
    int    idx, cyc, hold, abytes;
    bit    stalled, exp_err;
    eblk_t e;
    logic [127:0] s_aad, s_pt;
    logic [1:0]   s_fl;
    anb   = ab >> 3;
    pnb   = pb >> 3;
    aw    = (anb + 3) / 4;
    pw    = (pnb + 3) / 4;
    asend = (cut > 0) ? cut : aw;
    total = asend + pw;
    abytes = (cut > 0 && cut * 4 < anb) ? cut * 4 : anb;
    exp_err = (cut > 0);
    idx = 0; cyc = 0; hold = 0; stalled = 0;
    s_aad = '0; s_pt = '0; s_fl = '0;
    wq.delete();
    exp_q.delete();
    for (int i = 0; i < total; i++) wq.push_back($urandom);
    if (fixed) begin
      wq[asend]     = 32'hD931_3225;
      wq[asend + 1] = 32'hF8AA_AAAA;
    end
    build(abytes, 0, 1'b0, 1'b1);
    build(pnb, asend, 1'b1, 1'b0);
    cur_key = {$urandom, $urandom, $urandom, $urandom};
    cur_iv  = {$urandom, $urandom, $urandom};
    cur_ab  = 64'(ab);
    cur_pb  = 64'(pb);
    @(negedge clk);
    i_cipher_key = cur_key;
    i_iv         = cur_iv;
    i_aad_len    = cur_ab;
    i_pt_len     = cur_pb;
    i_start      = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      i_start      = 1'b0;
      i_cipher_key = {$urandom, $urandom, $urandom, $urandom};
      i_iv         = {$urandom, $urandom, $urandom};
      i_aad_len    = {$urandom, $urandom};
      i_pt_len     = {$urandom, $urandom};
      if (cyc > 4000) begin
        chk("timeout", 1, 0);
        break;
      end
      if (rst_mid && idx > asend) begin
        i_rst_n = 1'b0;
        i_word_valid = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        i_rst_n = 1'b1;
        return;
      end
      if (stalled) begin
        chk("hold_v", o_blk_valid, 1);
        chk("hold_aad", o_aad, s_aad);
        chk("hold_pt", o_plain_text, s_pt);
        chk("hold_fl", {o_new_instance, o_pt_instance}, s_fl);
      end
      stalled = 0;
      if (o_blk_valid) begin
        chk("wrdy_emit", o_word_ready, 0);
        case (rmode)
          0:       i_blk_ready = 1'b1;
          1:       i_blk_ready = ($urandom_range(0, 2) != 0);
          default: i_blk_ready = (hold >= 3);
        endcase
        hold++;
      end else begin
        i_blk_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        hold = 0;
      end
      if (o_blk_valid && i_blk_ready) begin
        if (exp_q.size() == 0) chk("extra_blk", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("aad", o_aad, e.pt ? 128'd0 : e.d);
          chk("pt", o_plain_text, e.pt ? e.d : 128'd0);
          chk("flags", {o_new_instance, o_pt_instance},
              {e.first && !e.pt, e.first && e.pt});
          chk("sizes", {o_aad_size, o_plain_text_size},
              {cur_ab, cur_pb});
          chk("key", o_cipher_key, cur_key);
          chk("iv", o_iv, cur_iv);
          if (e.pt) last_pt = o_plain_text;
        end
      end else if (o_blk_valid) begin
        stalled = 1;
        s_aad = o_aad;
        s_pt  = o_plain_text;
        s_fl  = {o_new_instance, o_pt_instance};
      end
      if (idx < total) begin
        i_word_valid = (vmode == 0) || ($urandom_range(0, 3) != 0);
        i_word = i_word_valid ? wq[idx] : $urandom;
        i_word_last = (idx == asend - 1) || (idx == total - 1);
        if (i_word_valid && o_word_ready) idx++;
      end else begin
        i_word_valid = 1'b0;
        i_word       = $urandom;
        i_word_last  = 1'b0;
      end
      i_start = o_busy && !o_done && ($urandom_range(0, 7) == 0);
      if (o_done) begin
        if (exp_cyc > 0) chk("cycles", cyc, exp_cyc);
        break;
      end
    end
    i_start      = 1'b0;
    i_word_valid = 1'b0;
    @(negedge clk);
    chk("done_once", {o_done, o_busy}, 0);
    chk("blk_left", exp_q.size(), 0);
    chk("words_used", idx, total);
    chk("len_err", o_len_err, exp_err);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_cipher_key = '0;
    i_iv         = '0;
    i_aad_len    = '0;
    i_pt_len     = '0;
    i_word       = '0;
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
    i_blk_ready  = 1'b0;
    last_pt      = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    i_rst_n = 1'b1;
    @(negedge clk);

    run_job(512, 512, 0, 0, 0, 0, 0, 41);
    run_job(0, 128, 0, 0, 0, 0, 0, 0);
    run_job(0, 40, 1, 1, 0, 1, 0, 0);
    chk("pt40", last_pt, 128'hD9313225F8000000_0000000000000000);
    run_job(256, 256, 0, 2, 0, 0, 0, 0);
    run_job(128, 256, 0, 0, 0, 0, 1, 0);
    run_job(96, 200, 1, 1, 0, 0, 0, 0);
`ifdef GCM_FEEDER_LEN_CHECK_EN
    run_job(128, 0, 0, 0, 2, 0, 0, 0);
    run_job(64, 64, 0, 0, 0, 0, 0, 0);
`endif
    for (int n = 0; n < 10; n++) begin
      run_job($urandom_range(0, 600), $urandom_range(0, 600),
              $urandom_range(0, 1), $urandom_range(0, 2), 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
